// File: rtl/instr_encoder_writer.sv
// rtl/instr_encoder_writer.sv - RV32I field encoder with FIFO-buffered imem loader; optional checksum under ENC_CHECKSUM_EN
module instr_encoder_writer #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        op_class,
    input  logic [4:0]        alu_ctl,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_busy,
`ifdef ENC_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PW    = PTR_W + 1;
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_STORE  = 3'd1;
    localparam logic [2:0] OP_RTYPE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_ITYPE  = 3'd4;
    localparam logic [2:0] OP_JAL    = 3'd5;
    localparam logic [2:0] OP_JALR   = 3'd6;
    localparam logic [2:0] OP_LUI    = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wc_q, wc_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic              err_q, err_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];

    logic        fifo_empty, fifo_full, pop, push, accept, overflow, start_ok;
    logic        alu_ok, enc_legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc_word, head_word;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_word  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign pop        = !fifo_empty && !imem_busy;
    assign start_ok   = (state_q == S_IDLE) && start;
    assign in_ready   = (state_q == S_LOAD) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign overflow   = accept && (acc_cnt_q == CNT_W'(MAX_WORDS));
    assign push       = accept && enc_legal && !overflow;

    assign imem_we    = pop;
    assign imem_addr  = addr_q;
    assign imem_wdata = fifo_empty ? 32'h0 : head_word;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign word_count = wc_q;

    // Translate the ALU control code into funct3/funct7, then assemble the word for the op class
    always_comb begin
        alu_ok    = 1'b1;
        f3        = 3'b000;
        f7        = 7'b0000000;
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (alu_ctl)
            5'b00000: f3 = 3'b000;
            5'b00001: begin f3 = 3'b000; f7 = 7'b0100000; end
            5'b00100: f3 = 3'b001;
            5'b00101: f3 = 3'b010;
            5'b01000: f3 = 3'b011;
            5'b01010: f3 = 3'b100;
            5'b01110: f3 = 3'b101;
            5'b00111: begin f3 = 3'b101; f7 = 7'b0100000; end
            5'b00011: f3 = 3'b110;
            5'b00010: f3 = 3'b111;
            default:  alu_ok = 1'b0;
        endcase
        case (op_class)
            OP_LOAD:   enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            OP_STORE:  enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            OP_RTYPE: begin
                enc_word  = {f7, rs2, rs1, f3, rd, 7'b0110011};
                enc_legal = alu_ok;
            end
            OP_BRANCH: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, alu_ctl[2:0], imm[4:1], imm[11], 7'b1100011};
                enc_legal = (alu_ctl[2:1] != 2'b01);
            end
            OP_ITYPE: begin
                // Shifts carry funct7 in the upper immediate bits and a 5-bit shamt below
                if (f3 == 3'b001 || f3 == 3'b101)
                    enc_word = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
                else
                    enc_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
                enc_legal = alu_ok && (alu_ctl != 5'b00001);
            end
            OP_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            OP_JALR:   enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            OP_LUI:    enc_word = {imm[31:12], rd, 7'b0110111};
            default:   enc_word = 32'h0;
        endcase
    end

    // Session sequencing, FIFO pointers, address/count advance and sticky error
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        addr_d    = addr_q;
        wc_d      = wc_q;
        acc_cnt_d = acc_cnt_q;
        err_d     = err_q;
        if (push) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            addr_d   = addr_q + ADDR_W'(4);
            wc_d     = wc_q + ADDR_W'(1);
        end
        if (accept && (!enc_legal || overflow))
            err_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    addr_d    = base_addr & ~ADDR_W'(3);
                    wc_d      = '0;
                    acc_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            S_LOAD:  if (accept && (in_last || overflow)) state_d = S_FLUSH;
            S_FLUSH: if (fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            addr_q    <= '0;
            wc_q      <= '0;
            acc_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            addr_q    <= addr_d;
            wc_q      <= wc_d;
            acc_cnt_q <= acc_cnt_d;
            err_q     <= err_d;
        end
    end

    // Word storage; contents are only observed behind the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    assign checksum = checksum_q;

    // Running XOR of every word handed to instruction memory this session
    always_comb begin
        checksum_d = checksum_q;
        if (start_ok)
            checksum_d = 32'h0;
        else if (pop)
            checksum_d = checksum_q ^ head_word;
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checksum_q <= 32'h0;
        else
            checksum_q <= checksum_d;
    end
`endif

endmodule

// File: tb/tb_instr_encoder_writer.sv
// tb/tb_instr_encoder_writer.sv - scoreboard bench for instr_encoder_writer
module tb_instr_encoder_writer;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [2:0]        op_class = 3'd0;
    logic [4:0]        alu_ctl = 5'd0;
    logic [4:0]        rd = 5'd0;
    logic [4:0]        rs1 = 5'd0;
    logic [4:0]        rs2 = 5'd0;
    logic [31:0]       imm = 32'h0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_busy = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] word_count;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    int                vectors = 0;
    int                miscompares = 0;
    logic [41:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [31:0]       exp_chk = 32'h0;
    int                n_ticks = 0;
    logic              done_s = 1'b0;

    instr_encoder_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .MAX_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op_class(op_class), .alu_ctl(alu_ctl), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_busy(imem_busy),
`ifdef ENC_CHECKSUM_EN
        .checksum(checksum),
`endif
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [41:0] e;
        @(negedge clk);
        n_ticks++;
        done_s = done;
        if (imem_we === 1'b1) begin
            vectors++;
            if (imem_busy) begin
                miscompares++;
                $display("FAIL write_while_busy addr=%h data=%h required no write", imem_addr, imem_wdata);
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write addr=%h data=%h required no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL imem_write got addr=%h data=%h required addr=%h data=%h",
                             imem_addr, imem_wdata, e[41:32], e[31:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [4:0] alu, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                           input logic last);
        op_class = op; alu_ctl = alu; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_last = last; in_valid = 1'b1;
    endtask

    task automatic accept(input logic legal, input logic [31:0] word);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end else if (legal) begin
            exp_q.push_back({exp_addr, word});
            exp_addr = exp_addr + ADDR_W'(4);
            exp_chk  = exp_chk ^ word;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] alu, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                        input logic last, input logic legal, input logic [31:0] word);
        present(op, alu, d, s1, s2, im, last);
        accept(legal, word);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        base_addr = a;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        exp_addr  = a & 10'h3FC;
        exp_chk   = 32'h0;
    endtask

    task automatic wait_done(input logic [ADDR_W-1:0] wc, input logic er);
        int n = 0;
        done_s = 1'b0;
        while (!done_s && n < 600) begin
            tick();
            n++;
        end
        vectors++;
        if (!done_s) begin miscompares++; $display("FAIL done_timeout done=%b required 1", done_s); end
        vectors++;
        if (word_count !== wc) begin miscompares++; $display("FAIL word_count got %0d required %0d", word_count, wc); end
        vectors++;
        if (err !== er) begin miscompares++; $display("FAIL err got %b required %b", err, er); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL missing_writes got %0d pending required 0", exp_q.size()); end
`ifdef ENC_CHECKSUM_EN
        vectors++;
        if (checksum !== exp_chk) begin miscompares++; $display("FAIL checksum got %h required %h", checksum, exp_chk); end
`endif
        tick();
        vectors++;
        if (done_s !== 1'b0) begin miscompares++; $display("FAIL done_width done=%b required 0", done_s); end
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, word_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b wc=%0d required all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, word_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rtype_add();
        do_start(10'h040);
        send(3'd2, 5'b00000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h002081B3);
        wait_done(10'd1, 1'b0);
    endtask

    task automatic test_load_store();
        do_start(10'h040);
        send(3'd0, 5'b00000, 5'd5, 5'd2, 5'd0, 32'd8,  1'b0, 1'b1, 32'h00812283);
        send(3'd1, 5'b00000, 5'd0, 5'd2, 5'd6, 32'd12, 1'b1, 1'b1, 32'h00612623);
        wait_done(10'd2, 1'b0);
    endtask

    task automatic test_formats();
        do_start(10'h100);
        send(3'd3, 5'b00000, 5'd0, 5'd1, 5'd2, 32'd8,         1'b0, 1'b1, 32'h00208463);
        send(3'd3, 5'b00000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF9,  1'b0, 1'b1, 32'hFE208CE3);
        send(3'd7, 5'b00000, 5'd1, 5'd0, 5'd0, 32'h12345000,  1'b0, 1'b1, 32'h123450B7);
        send(3'd4, 5'b00111, 5'd4, 5'd4, 5'd0, 32'd3,         1'b0, 1'b1, 32'h40325213);
        send(3'd4, 5'b00100, 5'd1, 5'd1, 5'd0, 32'h00000FE5,  1'b0, 1'b1, 32'h00509093);
        send(3'd2, 5'b00001, 5'd3, 5'd1, 5'd2, 32'h0,         1'b0, 1'b1, 32'h402081B3);
        send(3'd5, 5'b00000, 5'd1, 5'd0, 5'd0, 32'd8,         1'b0, 1'b1, 32'h008000EF);
        send(3'd6, 5'b00000, 5'd0, 5'd1, 5'd0, 32'h0,         1'b1, 1'b1, 32'h00008067);
        wait_done(10'd8, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        imem_busy = 1'b1;
        do_start(10'h000);
        for (int k = 1; k <= 4; k++)
            send(3'd2, 5'b00000, 5'(k), 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h00208033 | (k << 7));
        present(3'd2, 5'b00000, 5'd5, 5'd1, 5'd2, 32'h0, 1'b1);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got %b required 0", in_ready); end
        imem_busy = 1'b0;
        n_ticks = 0;
        accept(1'b1, 32'h00208033 | (5 << 7));
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n_ticks != 5) begin miscompares++; $display("FAIL drain_cycles got %0d required 5", n_ticks); end
        wait_done(10'd5, 1'b0);
    endtask

    task automatic test_errors();
        do_start(10'h080);
        send(3'd4, 5'b11111, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0, 32'h0);
        send(3'd4, 5'b00000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
        send(3'd4, 5'b00001, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0, 32'h0);
        send(3'd3, 5'b00010, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b0, 32'h0);
        send(3'd3, 5'b00011, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b0, 32'h0);
        send(3'd2, 5'b10000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 32'h0);
        send(3'd2, 5'b00010, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h0020F1B3);
        wait_done(10'd2, 1'b1);
        do_start(10'h000);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b required 0", err); end
        send(3'd2, 5'b00000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h002081B3);
        wait_done(10'd1, 1'b0);
    endtask

    task automatic test_wrap();
        do_start(10'h3FE);
        send(3'd4, 5'b00000, 5'd1, 5'd0, 5'd0, 32'd5,        1'b0, 1'b1, 32'h00500093);
        send(3'd7, 5'b00000, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b1, 32'h123450B7);
        wait_done(10'd2, 1'b0);
    endtask

    task automatic test_overflow();
        do_start(10'h000);
        for (int i = 0; i < 256; i++)
            send(3'd2, 5'b00000, 5'(i), 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h00208033 | ((i % 32) << 7));
        send(3'd2, 5'b00000, 5'd7, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL overflow_in_ready got %b required 0", in_ready); end
        wait_done(10'd256, 1'b1);
    endtask

    task automatic test_reset_mid_flush();
        imem_busy = 1'b1;
        do_start(10'h040);
        send(3'd2, 5'b00000, 5'd1, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h002080B3);
        send(3'd2, 5'b00000, 5'd2, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h00208133);
        rst_n     = 1'b0;
        imem_busy = 1'b0;
        #1;
        vectors++;
        if ({imem_we, busy, in_ready, word_count} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset we=%b busy=%b rdy=%b wc=%0d required all 0", imem_we, busy, in_ready, word_count);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        do_start(10'h040);
        send(3'd2, 5'b00000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h002081B3);
        wait_done(10'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_load_store();
        test_formats();
        test_back_to_back();
        test_errors();
        test_wrap();
        test_overflow();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Inverse of the ID-stage control decoder: takes decoded control fields (op class, 5-bit ALU control code, register indices, immediate) and encodes RV32I instruction words.
- Buffers the encoded words in a small FIFO and writes them sequentially into instruction memory through the imem load port.
- Used by the boot/self-test loader to place programs into instruction memory before the pipeline is released from stall.

Parameters:
- ADDR_W, 10, imem byte-address width; address wraps modulo 2^ADDR_W.
- FIFO_DEPTH, 4, encoded-word buffer depth; power of 2, minimum 2.
- MAX_WORDS, 256, maximum number of words per load session.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a session at base_addr.
- base_addr  in  ADDR_W  start byte address; bits [1:0] ignored and forced to 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_last  in  1  marks the final bundle of the session.
- op_class  in  3  0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE, 5 JAL, 6 JALR, 7 LUI.
- alu_ctl  in  5  ALU control code for RTYPE/ITYPE; for BRANCH, bits [2:0] = funct3.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  immediate; LUI uses imm[31:12].
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write byte address.
- imem_wdata  out  32  encoded word.
- imem_busy  in  1  memory cannot accept a write this cycle.
- busy  out  1  session active.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky; cleared by start.
- word_count  out  ADDR_W  words written in the current session.

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0, imem_addr 0.
- FSM:
  - IDLE -> LOAD on start.
  - LOAD -> FLUSH on an accepted bundle with in_last=1.
  - FLUSH -> DONE when the FIFO is empty and no write is pending.
  - DONE -> IDLE after 1 cycle.
- start in a non-IDLE state is ignored.
- in_ready = (state==LOAD) and FIFO not full. A bundle is accepted when in_valid & in_ready.
- Encode latency: the word is written into the FIFO on the accept edge (1 cycle). The earliest imem_we for that word is the next cycle.
- Drain: when the FIFO is not empty and imem_busy=0, assert imem_we with the head word and current address for exactly 1 cycle. Then pop, add 4 to the address (wrapping modulo 2^ADDR_W), and increment word_count.
- With imem_busy=1, imem_we stays 0 and the FIFO holds.
- A simultaneous push and pop on a full FIFO is allowed.
- Encoding, standard RV32I fields:
  - LOAD: funct3=010, opcode 0000011.
  - STORE: funct3=010, opcode 0100011.
  - JALR: opcode 1100111, funct3=000.
  - JAL: opcode 1101111, J-format imm.
  - LUI: opcode 0110111.
  - BRANCH: opcode 1100011, B-format imm. imm[0] is ignored.
- ALU code to funct3/funct7 map:
  - 00000 -> add (000).
  - 00001 -> sub (000, 0100000).
  - 00100 -> sll (001).
  - 00101 -> slt (010).
  - 01000 -> sltu (011).
  - 01010 -> xor (100).
  - 01110 -> srl (101).
  - 00111 -> sra (101, 0100000).
  - 00011 -> or (110).
  - 00010 -> and (111).
- ITYPE shifts: imm[11:5] is replaced by funct7 and imm[4:0] is used as shamt.
- Errors: an illegal bundle is consumed, not written, and sets err. Illegal means any of:
  - unmapped alu_ctl;
  - ITYPE with sub;
  - BRANCH funct3 of 010 or 011.
- Overflow: when an accept would make the session total exceed MAX_WORDS, set err, drop the bundle, and move to FLUSH.
- Reset mid-session: immediate return to IDLE, FIFO discarded, no further imem_we.

Optional Feature:
- Macro ENC_CHECKSUM_EN.
- When defined: adds output checksum[31:0], the XOR of every word written in the session. It is cleared on start and valid when done pulses.
- When undefined: the port is absent and no checksum logic is present.

Test Plan:
- start with base_addr=0x040; RTYPE add rd=3 rs1=1 rs2=2 with in_last -> imem_we once, addr 0x040, wdata 0x002081B3; then done pulse; word_count=1.
- LOAD rd=5 rs1=2 imm=8; STORE rs2=6 rs1=2 imm=12 -> wdata 0x00812283 at 0x040, then 0x00612623 at 0x044.
- BRANCH funct3=000 rs1=1 rs2=2 imm=8 -> 0x00208463. LUI rd=1 imm=0x12345000 -> 0x123450B7. ITYPE sra rd=4 rs1=4 imm=3 -> 0x40325213.
- Hold imem_busy=1 while pushing 5 bundles -> in_ready drops after 4 accepts. Release -> 5 ordered writes on consecutive cycles.
- alu_ctl=11111 on ITYPE -> no write, err=1, following valid bundle still written; next start clears err.
- base_addr=0x3FC (ADDR_W=10) with 2 words -> addresses 0x3FC then 0x000. With ENC_CHECKSUM_EN, checksum = XOR of both words. Assert rst_n low mid-FLUSH -> imem_we=0 immediately and state IDLE.
